regfile_scoreboard: RTL and testbench

The register-file scoreboard tracks pending writes to the 8-entry architectural register file and to the 4-bit flag register (z/n/c/v) for the two-slot VLIW datapath. It sits in decode, directly upstream of the register-file write ports. It stalls a bundle whenever either slot would read or overwrite a register whose result is still in flight. Writeback ports from both slots clear the pending state as results land in the register file.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/sb_busy_cell.sv | 18 +
 rtl/regfile_scoreboard.sv | 112 +++++++++++
 tb/tb_regfile_scoreboard.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, slot-issue payload and index decode for the register-file scoreboard.
package regfile_pkg;

  localparam int unsigned NREGS = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned SCW   = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] dst;
    logic          rda;
    logic [AW-1:0] src_a;
    logic          rdb;
    logic [AW-1:0] src_b;
    logic          flag_we;
    logic          flag_rd;
  } slot_issue_t;

  function automatic logic [NREGS-1:0] onehot(input logic [AW-1:0] idx);
    onehot = NREGS'(1) << idx;
  endfunction

endpackage

// File: rtl/sb_busy_cell.sv
// One pending-write bit; set wins over clear, err_c flags clear-while-idle or set/clear collision.
module sb_busy_cell (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clr,
  output logic busy,
  output logic err_c
);

  assign err_c = clr & (~busy | set);

  always_ff @(negedge clk) begin
    if (reset) busy <= 1'b0;
    else       busy <= (busy & ~clr) | set;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage scoreboard: stalls VLIW bundles on RAW/WAW/flag hazards against pending writes.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           issue_valid,
  input  logic           s1_we,
  input  logic [AW-1:0]  s1_dst,
  input  logic           s1_rda,
  input  logic           s1_rdb,
  input  logic [AW-1:0]  s1_src_a,
  input  logic [AW-1:0]  s1_src_b,
  input  logic           s1_flag_we,
  input  logic           s1_flag_rd,
  input  logic           s2_we,
  input  logic [AW-1:0]  s2_dst,
  input  logic           s2_rda,
  input  logic           s2_rdb,
  input  logic [AW-1:0]  s2_src_a,
  input  logic [AW-1:0]  s2_src_b,
  input  logic           s2_flag_we,
  input  logic           s2_flag_rd,
  input  logic           wb1_valid,
  input  logic [AW-1:0]  wb1_dst,
  input  logic           wb2_valid,
  input  logic [AW-1:0]  wb2_dst,
  input  logic           wb_flag_valid,
  output logic           issue_stall,
  output logic           issue_fire,
  output logic [NREGS-1:0] busy_o,
  output logic           flag_busy_o,
  output logic           err_o,
  output logic [SCW-1:0] stall_count_o
);

  localparam logic [SCW-1:0] CNT_MAX = '1;

  slot_issue_t      s1, s2;
  logic [NREGS-1:0] busy, set_vec, clr_vec, cell_err;
  logic             flag_busy, flag_set, flag_err;
  logic             hazard1, hazard2, dup_err, err_any;

  function automatic logic slot_hazard(input slot_issue_t s, input logic [NREGS-1:0] b,
                                       input logic fb);
    return (s.rda & b[s.src_a]) | (s.rdb & b[s.src_b]) | (s.we & b[s.dst]) |
           ((s.flag_rd | s.flag_we) & fb);
  endfunction

  assign s1 = '{we: s1_we, dst: s1_dst, rda: s1_rda, src_a: s1_src_a, rdb: s1_rdb,
                src_b: s1_src_b, flag_we: s1_flag_we, flag_rd: s1_flag_rd};
  assign s2 = '{we: s2_we, dst: s2_dst, rda: s2_rda, src_a: s2_src_a, rdb: s2_rdb,
                src_b: s2_src_b, flag_we: s2_flag_we, flag_rd: s2_flag_rd};

  // Hazards see registered busy only; intra-bundle reads of slot 1's dst read the old value.
  assign hazard1     = slot_hazard(s1, busy, flag_busy);
  assign hazard2     = slot_hazard(s2, busy, flag_busy);
  assign issue_stall = reset | (issue_valid & (hazard1 | hazard2));
  assign issue_fire  = issue_valid & ~issue_stall;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_fire && s1.we) set_vec = set_vec | onehot(s1.dst);
    if (issue_fire && s2.we) set_vec = set_vec | onehot(s2.dst);
    if (wb1_valid)           clr_vec = clr_vec | onehot(wb1_dst);
    if (wb2_valid)           clr_vec = clr_vec | onehot(wb2_dst);
  end

  assign flag_set = issue_fire & (s1.flag_we | s2.flag_we);

  for (genvar i = 0; i < int'(NREGS); i++) begin : g_cell
    sb_busy_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .set   (set_vec[i]),
      .clr   (clr_vec[i]),
      .busy  (busy[i]),
      .err_c (cell_err[i])
    );
  end

  sb_busy_cell u_flag_cell (
    .clk   (clk),
    .reset (reset),
    .set   (flag_set),
    .clr   (wb_flag_valid),
    .busy  (flag_busy),
    .err_c (flag_err)
  );

  // Duplicate targets still update the bit once but are protocol violations.
  assign dup_err = (wb1_valid & wb2_valid & (wb1_dst == wb2_dst)) |
                   (issue_fire & s1.we & s2.we & (s1.dst == s2.dst)) |
                   (issue_fire & s1.flag_we & s2.flag_we);
  assign err_any = (|cell_err) | flag_err | dup_err;

  assign busy_o      = busy;
  assign flag_busy_o = flag_busy;

  always_ff @(negedge clk) begin
    if (reset) begin
      err_o         <= 1'b0;
      stall_count_o <= '0;
    end else begin
      err_o <= err_o | err_any;
      if (issue_valid && issue_stall && stall_count_o != CNT_MAX)
        stall_count_o <= stall_count_o + SCW'(1);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scenario bench for regfile_scoreboard with a per-cycle reference model and expectation queue.
module tb_regfile_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       issue_valid = 1'b0;
  logic       s1_we = 1'b0, s1_rda = 1'b0, s1_rdb = 1'b0, s1_flag_we = 1'b0, s1_flag_rd = 1'b0;
  logic       s2_we = 1'b0, s2_rda = 1'b0, s2_rdb = 1'b0, s2_flag_we = 1'b0, s2_flag_rd = 1'b0;
  logic [2:0] s1_dst = '0, s1_src_a = '0, s1_src_b = '0;
  logic [2:0] s2_dst = '0, s2_src_a = '0, s2_src_b = '0;
  logic       wb1_valid = 1'b0, wb2_valid = 1'b0, wb_flag_valid = 1'b0;
  logic [2:0] wb1_dst = '0, wb2_dst = '0;
  logic        issue_stall, issue_fire, flag_busy_o, err_o;
  logic [7:0]  busy_o;
  logic [15:0] stall_count_o;

  typedef struct {
    logic        stall;
    logic        fire;
    logic [7:0]  busy;
    logic        fb;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  m_busy = '0;
  logic        m_fb = 1'b0, m_err = 1'b0;
  logic [15:0] m_cnt = '0;
  logic        last_stall, last_fire;
  int          n_total = 0, n_pass = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .s1_we(s1_we), .s1_dst(s1_dst), .s1_rda(s1_rda), .s1_rdb(s1_rdb),
    .s1_src_a(s1_src_a), .s1_src_b(s1_src_b), .s1_flag_we(s1_flag_we), .s1_flag_rd(s1_flag_rd),
    .s2_we(s2_we), .s2_dst(s2_dst), .s2_rda(s2_rda), .s2_rdb(s2_rdb),
    .s2_src_a(s2_src_a), .s2_src_b(s2_src_b), .s2_flag_we(s2_flag_we), .s2_flag_rd(s2_flag_rd),
    .wb1_valid(wb1_valid), .wb1_dst(wb1_dst), .wb2_valid(wb2_valid), .wb2_dst(wb2_dst),
    .wb_flag_valid(wb_flag_valid),
    .issue_stall(issue_stall), .issue_fire(issue_fire), .busy_o(busy_o),
    .flag_busy_o(flag_busy_o), .err_o(err_o), .stall_count_o(stall_count_o)
  );

  // Mid-cycle monitor for the combinational issue outputs.
  always @(posedge clk) begin
    if (q.size() != 0) begin
      n_total++;
      if (issue_stall !== q[0].stall)
        $display("FAIL sb_stall t=%0t got %b exp %b", $time, issue_stall, q[0].stall);
      else n_pass++;
      n_total++;
      if (issue_fire !== q[0].fire)
        $display("FAIL sb_fire t=%0t got %b exp %b", $time, issue_fire, q[0].fire);
      else n_pass++;
    end
  end

  // Post-edge monitor for the registered state.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      n_total++;
      if (busy_o !== e.busy) $display("FAIL sb_busy t=%0t got %h exp %h", $time, busy_o, e.busy);
      else n_pass++;
      n_total++;
      if (flag_busy_o !== e.fb) $display("FAIL sb_flag t=%0t got %b exp %b", $time, flag_busy_o, e.fb);
      else n_pass++;
      n_total++;
      if (err_o !== e.err) $display("FAIL sb_err t=%0t got %b exp %b", $time, err_o, e.err);
      else n_pass++;
      n_total++;
      if (stall_count_o !== e.cnt)
        $display("FAIL sb_cnt t=%0t got %h exp %h", $time, stall_count_o, e.cnt);
      else n_pass++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    issue_valid = 0;
    s1_we = 0; s1_rda = 0; s1_rdb = 0; s1_flag_we = 0; s1_flag_rd = 0;
    s2_we = 0; s2_rda = 0; s2_rdb = 0; s2_flag_we = 0; s2_flag_rd = 0;
    s1_dst = 0; s1_src_a = 0; s1_src_b = 0; s2_dst = 0; s2_src_a = 0; s2_src_b = 0;
    wb1_valid = 0; wb2_valid = 0; wb_flag_valid = 0; wb1_dst = 0; wb2_dst = 0;
  endtask

  // Advance one clock: model the expected outcome of the current inputs, queue it, take the edge.
  task automatic cyc();
    exp_t       e;
    logic [7:0] set_v, clr_v;
    logic       h1, h2, stall, fire, ev, fset;
    #1;
    h1 = (s1_rda && m_busy[s1_src_a]) || (s1_rdb && m_busy[s1_src_b]) ||
         (s1_we && m_busy[s1_dst]) || ((s1_flag_rd || s1_flag_we) && m_fb);
    h2 = (s2_rda && m_busy[s2_src_a]) || (s2_rdb && m_busy[s2_src_b]) ||
         (s2_we && m_busy[s2_dst]) || ((s2_flag_rd || s2_flag_we) && m_fb);
    stall = reset || (issue_valid && (h1 || h2));
    fire  = issue_valid && !stall;
    last_stall = issue_stall;
    last_fire  = issue_fire;
    set_v = '0; clr_v = '0; ev = 0;
    if (fire && s1_we) set_v[s1_dst] = 1'b1;
    if (fire && s2_we) set_v[s2_dst] = 1'b1;
    if (wb1_valid) clr_v[wb1_dst] = 1'b1;
    if (wb2_valid) clr_v[wb2_dst] = 1'b1;
    for (int i = 0; i < 8; i++)
      if (clr_v[i] && (!m_busy[i] || set_v[i])) ev = 1;
    if (wb1_valid && wb2_valid && wb1_dst == wb2_dst) ev = 1;
    if (fire && s1_we && s2_we && s1_dst == s2_dst) ev = 1;
    if (fire && s1_flag_we && s2_flag_we) ev = 1;
    fset = fire && (s1_flag_we || s2_flag_we);
    if (wb_flag_valid && (!m_fb || fset)) ev = 1;
    if (reset) begin
      m_busy = '0; m_fb = 0; m_err = 0; m_cnt = '0;
    end else begin
      m_busy = (m_busy & ~clr_v) | set_v;
      m_fb   = fset || (m_fb && !wb_flag_valid);
      m_err  = m_err || ev;
      if (issue_valid && stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    e.stall = stall; e.fire = fire; e.busy = m_busy; e.fb = m_fb; e.err = m_err; e.cnt = m_cnt;
    q.push_back(e);
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    issue_valid = 1;
    cyc();
    n_total++;
    if (last_stall !== 1'b1 || last_fire !== 1'b0)
      $display("FAIL reset_issue stall=%b fire=%b exp 1/0", last_stall, last_fire);
    else n_pass++;
    n_total++;
    if (busy_o !== 8'h00 || flag_busy_o !== 1'b0 || err_o !== 1'b0 || stall_count_o !== 16'h0)
      $display("FAIL reset_state busy=%h fb=%b err=%b cnt=%h exp all 0",
               busy_o, flag_busy_o, err_o, stall_count_o);
    else n_pass++;
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_raw();
    idle_inputs();
    issue_valid = 1; s1_we = 1; s1_dst = 3;
    cyc();
    n_total++;
    if (last_fire !== 1'b1 || busy_o !== 8'h08)
      $display("FAIL raw_produce fire=%b busy=%h exp 1/08", last_fire, busy_o);
    else n_pass++;
    idle_inputs();
    issue_valid = 1; s2_rda = 1; s2_src_a = 3;
    cyc();
    n_total++;
    if (last_stall !== 1'b1 || busy_o !== 8'h08)
      $display("FAIL raw_stall stall=%b busy=%h exp 1/08", last_stall, busy_o);
    else n_pass++;
    wb1_valid = 1; wb1_dst = 3;
    cyc();
    n_total++;
    if (last_stall !== 1'b1 || busy_o !== 8'h00)
      $display("FAIL raw_no_bypass stall=%b busy=%h exp 1/00", last_stall, busy_o);
    else n_pass++;
    wb1_valid = 0;
    cyc();
    n_total++;
    if (last_fire !== 1'b1 || busy_o !== 8'h00)
      $display("FAIL raw_release fire=%b busy=%h exp 1/00", last_fire, busy_o);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_intra_bundle();
    idle_inputs();
    issue_valid = 1; s1_we = 1; s1_dst = 5; s2_rdb = 1; s2_src_b = 5;
    cyc();
    n_total++;
    if (last_stall !== 1'b0 || busy_o !== 8'h20 || err_o !== 1'b0)
      $display("FAIL intra_read stall=%b busy=%h err=%b exp 0/20/0", last_stall, busy_o, err_o);
    else n_pass++;
    idle_inputs();
    wb1_valid = 1; wb1_dst = 5;
    cyc();
    idle_inputs();
    issue_valid = 1; s1_we = 1; s1_dst = 2; s2_we = 1; s2_dst = 2;
    cyc();
    n_total++;
    if (last_fire !== 1'b1 || busy_o !== 8'h04 || err_o !== 1'b1)
      $display("FAIL intra_dup_dst fire=%b busy=%h err=%b exp 1/04/1", last_fire, busy_o, err_o);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_flags();
    idle_inputs();
    issue_valid = 1; s1_flag_we = 1;
    cyc();
    n_total++;
    if (last_fire !== 1'b1 || flag_busy_o !== 1'b1)
      $display("FAIL flag_set fire=%b fb=%b exp 1/1", last_fire, flag_busy_o);
    else n_pass++;
    idle_inputs();
    issue_valid = 1; s2_flag_rd = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_total++;
      if (last_stall !== 1'b1) $display("FAIL flag_stall cycle %0d stall=%b exp 1", i, last_stall);
      else n_pass++;
    end
    wb_flag_valid = 1;
    cyc();
    n_total++;
    if (last_stall !== 1'b1 || flag_busy_o !== 1'b0)
      $display("FAIL flag_wb stall=%b fb=%b exp 1/0", last_stall, flag_busy_o);
    else n_pass++;
    wb_flag_valid = 0;
    cyc();
    n_total++;
    if (last_fire !== 1'b1 || err_o !== 1'b0)
      $display("FAIL flag_release fire=%b err=%b exp 1/0", last_fire, err_o);
    else n_pass++;
    idle_inputs();
    issue_valid = 1; s1_flag_we = 1; s2_flag_we = 1;
    cyc();
    n_total++;
    if (last_fire !== 1'b1 || flag_busy_o !== 1'b1 || err_o !== 1'b1)
      $display("FAIL flag_dup fire=%b fb=%b err=%b exp 1/1/1", last_fire, flag_busy_o, err_o);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_errors();
    idle_inputs();
    wb2_valid = 1; wb2_dst = 6;
    cyc();
    n_total++;
    if (err_o !== 1'b1 || busy_o !== 8'h00)
      $display("FAIL err_idle_clear err=%b busy=%h exp 1/00", err_o, busy_o);
    else n_pass++;
    do_reset();
    issue_valid = 1; s1_we = 1; s1_dst = 1;
    cyc();
    idle_inputs();
    wb1_valid = 1; wb1_dst = 1; wb2_valid = 1; wb2_dst = 1;
    cyc();
    n_total++;
    if (err_o !== 1'b1 || busy_o !== 8'h00)
      $display("FAIL err_dup_wb err=%b busy=%h exp 1/00", err_o, busy_o);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      issue_valid = 1'($urandom_range(0, 1));
      s1_we = 1'($urandom_range(0, 1)); s1_dst = 3'($urandom);
      s1_rda = 1'($urandom_range(0, 1)); s1_src_a = 3'($urandom);
      s1_rdb = 1'($urandom_range(0, 1)); s1_src_b = 3'($urandom);
      s1_flag_we = ($urandom_range(0, 5) == 0); s1_flag_rd = ($urandom_range(0, 5) == 0);
      s2_we = 1'($urandom_range(0, 1)); s2_dst = 3'($urandom);
      s2_rda = 1'($urandom_range(0, 1)); s2_src_a = 3'($urandom);
      s2_rdb = 1'($urandom_range(0, 1)); s2_src_b = 3'($urandom);
      s2_flag_we = ($urandom_range(0, 5) == 0); s2_flag_rd = ($urandom_range(0, 5) == 0);
      wb1_valid = 1'($urandom_range(0, 1)); wb1_dst = 3'($urandom);
      wb2_valid = 1'($urandom_range(0, 1)); wb2_dst = 3'($urandom);
      wb_flag_valid = ($urandom_range(0, 3) == 0);
      cyc();
      if (i % 100 == 99) do_reset();
    end
    do_reset();
  endtask

  task automatic test_stall_count();
    idle_inputs();
    issue_valid = 1; s1_we = 1; s1_dst = 0;
    cyc();
    idle_inputs();
    s1_rda = 1; s1_src_a = 0;
    for (int i = 0; i < 10; i++) cyc();
    n_total++;
    if (stall_count_o !== 16'h0000)
      $display("FAIL cnt_idle got %h exp 0000", stall_count_o);
    else n_pass++;
    issue_valid = 1;
    for (int i = 0; i < 70000; i++) cyc();
    n_total++;
    if (stall_count_o !== 16'hFFFF)
      $display("FAIL cnt_saturate got %h exp ffff", stall_count_o);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    issue_valid = 1;
    for (int i = 0; i < 4; i++) begin
      s1_we = 1; s1_dst = 3'(2 * i); s2_we = 1; s2_dst = 3'(2 * i + 1);
      s2_flag_we = (i == 3);
      cyc();
    end
    n_total++;
    if (busy_o !== 8'hFF || flag_busy_o !== 1'b1)
      $display("FAIL mid_fill busy=%h fb=%b exp ff/1", busy_o, flag_busy_o);
    else n_pass++;
    idle_inputs();
    issue_valid = 1; s1_rda = 1; s1_src_a = 7;
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_total++;
      if (last_fire !== 1'b0 || last_stall !== 1'b1)
        $display("FAIL mid_reset_issue fire=%b stall=%b exp 0/1", last_fire, last_stall);
      else n_pass++;
    end
    n_total++;
    if (busy_o !== 8'h00 || flag_busy_o !== 1'b0 || err_o !== 1'b0 || stall_count_o !== 16'h0)
      $display("FAIL mid_reset_state busy=%h fb=%b err=%b cnt=%h exp all 0",
               busy_o, flag_busy_o, err_o, stall_count_o);
    else n_pass++;
    reset = 0;
    idle_inputs();
    wb1_valid = 1; wb1_dst = 4;
    cyc();
    n_total++;
    if (err_o !== 1'b1) $display("FAIL mid_late_wb err=%b exp 1", err_o);
    else n_pass++;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_intra_bundle();
    test_flags();
    test_errors();
    test_back_to_back();
    test_stall_count();
    test_reset_mid();
    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
